if_stage: RTL and testbench

- Instruction fetch stage of the 5-stage pipeline.
- Drives the IF/ID pipeline register (if_pc, if_insn, if_en) that the ID-stage decoder consumes.
- Takes the decoder's branch result (br_taken, br_addr) and the pipeline controller's stall, flush and new_pc.
- Fetches words as a bus master through a req/grant/as/rdy handshake.
- One branch delay slot: the instruction after a branch always executes.

---
 rtl/if_stage_pkg.sv | 20 ++
 rtl/if_bus_if.sv | 97 +++++++++
 rtl/if_stage.sv | 90 +++++++++
 tb/tb_if_stage.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/if_stage_pkg.sv
// rtl/if_stage_pkg.sv - shared widths, bus levels, NOP encoding and fetch FSM states
package if_stage_pkg;

  localparam int WORD_ADDR_W = 30;
  localparam int WORD_DATA_W = 32;

  localparam logic READ     = 1'b1;
  localparam logic ENABLE_  = 1'b0;
  localparam logic DISABLE_ = 1'b1;

  localparam logic [WORD_DATA_W-1:0] ISA_NOP = 32'h0000_0000;

  typedef enum logic [1:0] {
    IF_STATE_IDLE   = 2'd0,
    IF_STATE_REQ    = 2'd1,
    IF_STATE_ACCESS = 2'd2,
    IF_STATE_STALL  = 2'd3
  } if_state_e;

endpackage

// File: rtl/if_bus_if.sv
// rtl/if_bus_if.sv - fetch bus master: req/grant/as/rdy FSM, stall buffer and busy
module if_bus_if
  import if_stage_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset_,
  input  logic                   stall,
  input  logic                   flush,
  input  logic [WORD_ADDR_W-1:0] fetch_pc,
  input  logic [WORD_ADDR_W-1:0] next_pc,
  output logic                   busy,
  output logic [WORD_DATA_W-1:0] data,
  output logic                   valid,
  output logic                   bus_req_,
  input  logic                   bus_grnt_,
  output logic                   bus_as_,
  output logic                   bus_rw,
  output logic [WORD_ADDR_W-1:0] bus_addr,
  input  logic [WORD_DATA_W-1:0] bus_rd_data,
  input  logic                   bus_rdy_
);

  if_state_e              state, state_nx;
  logic                   req_nx, as_nx;
  logic [WORD_ADDR_W-1:0] addr_nx;
  logic [WORD_DATA_W-1:0] buffer, buffer_nx;

  assign bus_rw = READ;

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state    <= IF_STATE_IDLE;
      bus_req_ <= DISABLE_;
      bus_as_  <= DISABLE_;
      bus_addr <= '0;
      buffer   <= '0;
    end else begin
      state    <= state_nx;
      bus_req_ <= req_nx;
      bus_as_  <= as_nx;
      bus_addr <= addr_nx;
      buffer   <= buffer_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    req_nx    = bus_req_;
    as_nx     = bus_as_;
    addr_nx   = bus_addr;
    buffer_nx = buffer;
    busy      = 1'b1;
    valid     = 1'b0;
    data      = bus_rd_data;
    case (state)
      IF_STATE_IDLE: begin
        req_nx   = ENABLE_;
        state_nx = IF_STATE_REQ;
      end
      IF_STATE_REQ: begin
        if (bus_grnt_ == ENABLE_) begin
          as_nx    = ENABLE_;
          addr_nx  = fetch_pc;
          state_nx = IF_STATE_ACCESS;
        end
      end
      IF_STATE_ACCESS: begin
        if (bus_rdy_ == ENABLE_) begin
          busy  = 1'b0;
          valid = 1'b1;
          // Park the word while the pipeline is stalled; bus stays requested.
          if (stall) begin
            buffer_nx = bus_rd_data;
            as_nx     = DISABLE_;
            state_nx  = IF_STATE_STALL;
          end else begin
            addr_nx = next_pc;
          end
        end
      end
      IF_STATE_STALL: begin
        busy  = 1'b0;
        valid = 1'b1;
        data  = buffer;
        if (!stall) state_nx = IF_STATE_REQ;
      end
      default: state_nx = IF_STATE_IDLE;
    endcase
    if (flush) begin
      busy     = 1'b0;
      state_nx = IF_STATE_IDLE;
      req_nx   = DISABLE_;
      as_nx    = DISABLE_;
    end
  end

endmodule

// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch stage with IF/ID register; IF_PERF_CNT_EN adds fetch/wait counters
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [WORD_ADDR_W-1:0] RESET_VECTOR = 30'h0,
  parameter logic [WORD_DATA_W-1:0] NOP_INSN     = ISA_NOP
) (
  input  logic                   clk,
  input  logic                   reset_,
  input  logic                   stall,
  input  logic                   flush,
  input  logic [WORD_ADDR_W-1:0] new_pc,
  input  logic                   br_taken,
  input  logic [WORD_ADDR_W-1:0] br_addr,
  output logic                   busy,
  output logic                   bus_req_,
  input  logic                   bus_grnt_,
  output logic                   bus_as_,
  output logic                   bus_rw,
  output logic [WORD_ADDR_W-1:0] bus_addr,
  input  logic [WORD_DATA_W-1:0] bus_rd_data,
  input  logic                   bus_rdy_,
  output logic [WORD_ADDR_W-1:0] if_pc,
  output logic [WORD_DATA_W-1:0] if_insn,
  output logic                   if_en
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]            if_fetch_cnt,
  output logic [31:0]            if_wait_cnt
`endif
);

  logic [WORD_ADDR_W-1:0] fetch_pc, next_pc;
  logic [WORD_DATA_W-1:0] data;
  logic                   valid, deliver;

  // Branch is resolved against the instruction in IF/ID, so the slot after it still issues.
  assign next_pc = (br_taken && if_en) ? br_addr : fetch_pc + 30'd1;
  assign deliver = valid && !stall && !flush;

  if_bus_if u_bus_if (
    .clk         (clk),
    .reset_      (reset_),
    .stall       (stall),
    .flush       (flush),
    .fetch_pc    (fetch_pc),
    .next_pc     (next_pc),
    .busy        (busy),
    .data        (data),
    .valid       (valid),
    .bus_req_    (bus_req_),
    .bus_grnt_   (bus_grnt_),
    .bus_as_     (bus_as_),
    .bus_rw      (bus_rw),
    .bus_addr    (bus_addr),
    .bus_rd_data (bus_rd_data),
    .bus_rdy_    (bus_rdy_)
  );

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      fetch_pc <= RESET_VECTOR;
      if_pc    <= RESET_VECTOR;
      if_insn  <= NOP_INSN;
      if_en    <= 1'b0;
    end else if (flush) begin
      fetch_pc <= new_pc;
      if_insn  <= NOP_INSN;
      if_en    <= 1'b0;
    end else if (deliver) begin
      if_pc    <= fetch_pc;
      if_insn  <= data;
      if_en    <= 1'b1;
      fetch_pc <= next_pc;
    end
  end

`ifdef IF_PERF_CNT_EN
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      if_fetch_cnt <= '0;
      if_wait_cnt  <= '0;
    end else begin
      if (deliver) if_fetch_cnt <= if_fetch_cnt + 32'd1;
      if (busy)    if_wait_cnt  <= if_wait_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - directed plus randomized checks of if_stage against a transaction-level fetch model
module tb_if_stage;

  logic        clk = 1'b0;
  logic        reset_, stall, flush, br_taken, bus_grnt_, bus_rdy_;
  logic [29:0] new_pc, br_addr;
  logic        busy, bus_req_, bus_as_, bus_rw, if_en;
  logic [29:0] bus_addr, if_pc;
  logic [31:0] bus_rd_data, if_insn;
`ifdef IF_PERF_CNT_EN
  logic [31:0] if_fetch_cnt, if_wait_cnt;
`endif

  int          tests = 0;
  int          fails = 0;
  logic        use_fixed;
  logic [31:0] fixed_data, salt;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [29:0] a, input logic [31:0] s);
    return {2'b00, a} ^ s;
  endfunction

  assign bus_rd_data = use_fixed ? fixed_data : mem_word(bus_addr, salt);

  if_stage dut (
    .clk         (clk),
    .reset_      (reset_),
    .stall       (stall),
    .flush       (flush),
    .new_pc      (new_pc),
    .br_taken    (br_taken),
    .br_addr     (br_addr),
    .busy        (busy),
    .bus_req_    (bus_req_),
    .bus_grnt_   (bus_grnt_),
    .bus_as_     (bus_as_),
    .bus_rw      (bus_rw),
    .bus_addr    (bus_addr),
    .bus_rd_data (bus_rd_data),
    .bus_rdy_    (bus_rdy_),
    .if_pc       (if_pc),
    .if_insn     (if_insn),
    .if_en       (if_en)
`ifdef IF_PERF_CNT_EN
    ,
    .if_fetch_cnt(if_fetch_cnt),
    .if_wait_cnt (if_wait_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Model state: what the fetch stream should look like at the transaction level
  logic [29:0] m_pc, m_fetch, nxt;
  logic [31:0] m_insn;
  logic        m_en, pending, beat, busy_exp;
  int          deliveries;
  int          waited;

  initial begin
    reset_ = 1'b0; stall = 1'b0; flush = 1'b0; new_pc = '0;
    br_taken = 1'b0; br_addr = '0; bus_grnt_ = 1'b1; bus_rdy_ = 1'b1;
    use_fixed = 1'b1; fixed_data = 32'h1234_5678; salt = '0;
    tick; tick;

    chk("rst_if_pc", 32'(if_pc), 32'h0);
    chk("rst_if_insn", if_insn, 32'h0);
    chk("rst_if_en", 32'(if_en), 32'h0);
    chk("rst_req", 32'(bus_req_), 32'h1);
    chk("rst_as", 32'(bus_as_), 32'h1);
    chk("rst_addr", 32'(bus_addr), 32'h0);
    chk("rst_rw", 32'(bus_rw), 32'h1);
    chk("rst_busy", 32'(busy), 32'h1);

    bus_grnt_ = 1'b0; bus_rdy_ = 1'b0; reset_ = 1'b1;
    tick;
    chk("c1_req", 32'(bus_req_), 32'h0);
    chk("c1_as", 32'(bus_as_), 32'h1);
    tick;
    chk("c2_addr", 32'(bus_addr), 32'h0);
    chk("c2_as", 32'(bus_as_), 32'h0);
    tick;
    chk("c3_if_pc", 32'(if_pc), 32'h0);
    chk("c3_if_insn", if_insn, 32'h1234_5678);
    chk("c3_if_en", 32'(if_en), 32'h1);

    use_fixed = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      tick;
      chk("seq_pc", 32'(if_pc), i);
      chk("seq_insn", if_insn, i);
      chk("seq_busy", 32'(busy), 32'h0);
    end

    use_fixed = 1'b1; fixed_data = 32'hAAAA_0001; stall = 1'b1;
    tick;
    chk("stl_pc", 32'(if_pc), 32'h3);
    chk("stl_insn", if_insn, 32'h3);
    chk("stl_busy", 32'(busy), 32'h0);
    chk("stl_as", 32'(bus_as_), 32'h1);
    stall = 1'b0; use_fixed = 1'b0;
    #1;
    chk("stl_rel_busy", 32'(busy), 32'h0);
    tick;
    chk("stl_out_insn", if_insn, 32'hAAAA_0001);
    chk("stl_out_pc", 32'(if_pc), 32'h4);
    chk("stl_req_busy", 32'(busy), 32'h1);
    chk("stl_req_req", 32'(bus_req_), 32'h0);
    tick;
    chk("stl_re_addr", 32'(bus_addr), 32'h5);
    tick;
    chk("stl_re_pc", 32'(if_pc), 32'h5);

    flush = 1'b1; new_pc = 30'h200;
    #1;
    chk("fl_busy", 32'(busy), 32'h0);
    tick;
    chk("fl_en", 32'(if_en), 32'h0);
    chk("fl_insn", if_insn, 32'h0);
    chk("fl_pc", 32'(if_pc), 32'h5);
    flush = 1'b0;
    tick; tick;
    chk("fl_addr", 32'(bus_addr), 32'h200);
    tick;
    chk("fl_first_pc", 32'(if_pc), 32'h200);

    flush = 1'b1; new_pc = 30'h10;
    tick;
    flush = 1'b0;
    tick; tick; tick;
    chk("br_pc0", 32'(if_pc), 32'h10);
    br_taken = 1'b1; br_addr = 30'h100;
    tick;
    chk("br_slot", 32'(if_pc), 32'h11);
    br_taken = 1'b0;
    tick;
    chk("br_target", 32'(if_pc), 32'h100);
    chk("br_tgt_insn", if_insn, 32'h100);
    tick;
    chk("br_after", 32'(if_pc), 32'h101);

    // Randomized phase: start from a known flush
    salt = $urandom; flush = 1'b1; new_pc = 30'($urandom);
    tick;
    m_pc = 30'h101; m_insn = '0; m_en = 1'b0; m_fetch = new_pc; pending = 1'b0;
    deliveries = 0;
    for (int c = 0; c < 600; c++) begin
      stall     = ($urandom % 4) == 0;
      flush     = ($urandom % 32) == 0;
      new_pc    = 30'($urandom);
      bus_grnt_ = ($urandom % 10) < 3;
      bus_rdy_  = ($urandom % 10) < 3;
      br_taken  = ($urandom % 6) == 0;
      br_addr   = 30'($urandom);
      #1;
      beat     = (bus_as_ == 1'b0) && (bus_rdy_ == 1'b0);
      busy_exp = flush ? 1'b0 : pending ? 1'b0 : (bus_as_ == 1'b0) ? bus_rdy_ : 1'b1;
      chk("rnd_busy", 32'(busy), 32'(busy_exp));
      if (beat) chk("rnd_addr", 32'(bus_addr), 32'(m_fetch));
      tick;
      if (flush) begin
        m_fetch = new_pc; m_en = 1'b0; m_insn = '0; pending = 1'b0;
      end else if (stall) begin
        if (beat) pending = 1'b1;
      end else if (beat || pending) begin
        nxt     = (br_taken && m_en) ? br_addr : m_fetch + 30'd1;
        m_pc    = m_fetch;
        m_insn  = mem_word(m_fetch, salt);
        m_en    = 1'b1;
        m_fetch = nxt;
        pending = 1'b0;
        deliveries++;
      end
      chk("rnd_pc", 32'(if_pc), 32'(m_pc));
      chk("rnd_insn", if_insn, m_insn);
      chk("rnd_en", 32'(if_en), 32'(m_en));
    end
    chk("rnd_progress", 32'(deliveries > 60), 32'h1);

    stall = 1'b0; flush = 1'b0; bus_grnt_ = 1'b0; bus_rdy_ = 1'b1; br_taken = 1'b0;
    waited = 0;
    while (bus_as_ !== 1'b0 && waited < 20) begin
      tick;
      waited++;
    end
    chk("ar_in_access", 32'(bus_as_), 32'h0);
    #3;
    reset_ = 1'b0;
    #1;
    chk("ar_as", 32'(bus_as_), 32'h1);
    chk("ar_req", 32'(bus_req_), 32'h1);
    chk("ar_en", 32'(if_en), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
